// File: rtl/agdc_pkg.sv
// Shared definitions for the garage door controller: state codes and
// motion-direction encoding.
package agdc_pkg;

  // 3-bit state codes; the numeric values are visible on the State debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MV_UP = 3'd1,
    ST_MV_DN = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // True for the two motor-on states.
  function automatic logic is_moving(input state_e s);
    return (s == ST_MV_UP) || (s == ST_MV_DN);
  endfunction

endpackage

// File: rtl/agdc_act_sync.sv
// Push-button front end: SYNC_STAGES-deep synchroniser for the asynchronous
// Activate level, followed by a rising-edge detector. o_act_pulse is high for
// one cycle per button press.
module agdc_act_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_activate,
  output logic o_act_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw level through the synchroniser and keep one delayed copy
  // of the synchronised level for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_activate};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Because the flops clear on reset, a button held through reset still
  // produces exactly one pulse once reset is released.
  assign o_act_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/agdc_multimode_ctrl.sv
// Garage door controller with pause, obstacle reversal, motion watchdog and
// latched fault. Motor commands are registered Moore outputs.
// Optional feature: define AGDC_AUTO_CLOSE_EN to build the auto-close counter,
// which starts closing a door left fully open for AUTO_CLOSE_CYCLES cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | motor off, waiting for a button press (or auto-close)
// ST_MV_UP | motor driving the door open
// ST_MV_DN | motor driving the door closed
// ST_HALT  | paused mid-travel; next press reverses the last direction
// ST_FAULT | latched error; only reset leaves this state
module agdc_multimode_ctrl
  import agdc_pkg::*;
#(
  parameter int MOVE_TIMEOUT      = 1000,
  parameter int AUTO_CLOSE_CYCLES = 5000,
  parameter int SYNC_STAGES       = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       Obstacle,
  output logic       UP_M,
  output logic       DN_M,
  output logic       Fault,
  output logic [2:0] State
);

  localparam int            TW      = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MOVE_TIMEOUT - 1);

  if (MOVE_TIMEOUT < 2 || AUTO_CLOSE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_param
    $error("agdc_multimode_ctrl: parameter out of range");
  end

  state_e        r_state;
  state_e        w_next;
  logic          r_up_m;
  logic          r_dn_m;
  logic          r_fault;
  logic          r_last_dir;
  logic [TW-1:0] r_move_tmr;
  logic          w_act;
  logic          w_timeout;
  logic          w_enter_move;
  logic          w_ac_done;

  agdc_act_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_act_sync (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_activate (Activate),
    .o_act_pulse(w_act)
  );

`ifdef AGDC_AUTO_CLOSE_EN
  localparam int            AW      = $clog2(AUTO_CLOSE_CYCLES + 1);
  localparam logic [AW-1:0] AC_LAST = AW'(AUTO_CLOSE_CYCLES - 1);

  logic [AW-1:0] r_ac_cnt;
  logic          w_ac_open;

  assign w_ac_open = (r_state == ST_IDLE) && UP_Max && !DN_Max;
  assign w_ac_done = w_ac_open && (r_ac_cnt == AC_LAST);

  // Count cycles spent idle with the door fully open; any press, leaving the
  // open condition, or the auto-close itself restarts the count.
  always_ff @(posedge CLK) begin
    if (RST || !w_ac_open || w_act || w_ac_done) begin
      r_ac_cnt <= '0;
    end else begin
      r_ac_cnt <= r_ac_cnt + AW'(1);
    end
  end
`else
  assign w_ac_done = 1'b0;
`endif

  assign w_timeout    = (r_move_tmr == TO_LAST);
  assign w_enter_move = is_moving(w_next) && (w_next != r_state);

  // Next-state decode; limit inputs are checked ahead of the button so a
  // press that coincides with reaching a limit is dropped.
  always_comb begin
    w_next = r_state;
    if (UP_Max && DN_Max) begin
      w_next = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_act)          w_next = UP_Max ? ST_MV_DN : ST_MV_UP;
          else if (w_ac_done) w_next = ST_MV_DN;
        end
        ST_MV_UP: begin
          if (UP_Max)         w_next = ST_IDLE;
          else if (w_act)     w_next = ST_HALT;
          else if (w_timeout) w_next = ST_FAULT;
        end
        ST_MV_DN: begin
          if (DN_Max)         w_next = ST_IDLE;
          else if (Obstacle)  w_next = ST_MV_UP;
          else if (w_act)     w_next = ST_HALT;
          else if (w_timeout) w_next = ST_FAULT;
        end
        ST_HALT: begin
          if (w_act) w_next = (r_last_dir == DIR_UP) ? ST_MV_DN : ST_MV_UP;
        end
        ST_FAULT: w_next = ST_FAULT;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // State register, registered motor/fault outputs, direction memory and
  // motion watchdog timer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_up_m     <= 1'b0;
      r_dn_m     <= 1'b0;
      r_fault    <= 1'b0;
      r_last_dir <= DIR_DN;
      r_move_tmr <= '0;
    end else begin
      r_state <= w_next;
      r_up_m  <= (w_next == ST_MV_UP);
      r_dn_m  <= (w_next == ST_MV_DN);
      r_fault <= (w_next == ST_FAULT);
      if (w_enter_move) begin
        r_last_dir <= (w_next == ST_MV_UP) ? DIR_UP : DIR_DN;
      end
      if (w_enter_move || !is_moving(w_next)) begin
        r_move_tmr <= '0;
      end else begin
        r_move_tmr <= r_move_tmr + TW'(1);
      end
    end
  end

  assign UP_M  = r_up_m;
  assign DN_M  = r_dn_m;
  assign Fault = r_fault;
  assign State = r_state;

endmodule

// File: tb/tb_agdc_multimode_ctrl.sv
// Directed testbench for agdc_multimode_ctrl with MOVE_TIMEOUT=8,
// AUTO_CLOSE_CYCLES=16, SYNC_STAGES=2 and a 20 ns clock. Inputs change and
// outputs are sampled 1 ns after the rising edge.
module tb_agdc_multimode_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_MV_UP = 1;
  localparam int S_MV_DN = 2;
  localparam int S_HALT  = 3;
  localparam int S_FAULT = 4;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic       Activate = 1'b0;
  logic       UP_Max   = 1'b0;
  logic       DN_Max   = 1'b0;
  logic       Obstacle = 1'b0;
  logic       UP_M;
  logic       DN_M;
  logic       Fault;
  logic [2:0] State;

  int n_checks = 0;
  int n_errors = 0;

  agdc_multimode_ctrl #(
    .MOVE_TIMEOUT     (8),
    .AUTO_CLOSE_CYCLES(16),
    .SYNC_STAGES      (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Activate(Activate),
    .UP_Max  (UP_Max),
    .DN_Max  (DN_Max),
    .Obstacle(Obstacle),
    .UP_M    (UP_M),
    .DN_M    (DN_M),
    .Fault   (Fault),
    .State   (State)
  );

  // 20 ns clock
  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One press: high for one edge; the state changes on the third edge.
  task automatic press();
    Activate = 1'b1;
    tick();
    Activate = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // 1: reset state
    tick();
    RST = 1'b0;
    check("rst_up_m", UP_M, 0);
    check("rst_dn_m", DN_M, 0);
    check("rst_fault", Fault, 0);
    check("rst_state", State, S_IDLE);

    // 2: open door, press -> closing; bottom limit -> idle
    UP_Max = 1'b1;
    Activate = 1'b1;
    tick();
    Activate = 1'b0;
    tick();
    check("sync_latency_idle", State, S_IDLE);
    tick();
    check("open_press_dn_m", DN_M, 1);
    check("open_press_state", State, S_MV_DN);
    UP_Max = 1'b0;
    DN_Max = 1'b1;
    tick();
    check("dn_limit_state", State, S_IDLE);
    check("dn_limit_dn_m", DN_M, 0);
    tick();
    check("single_pulse_idle", State, S_IDLE);

    // 3: obstacle reversal clears the watchdog
    DN_Max = 1'b0;
    UP_Max = 1'b1;
    press();
    check("rev_start_state", State, S_MV_DN);
    UP_Max = 1'b0;
    tick(2);
    Obstacle = 1'b1;
    tick();
    check("rev_up_m", UP_M, 1);
    check("rev_dn_m", DN_M, 0);
    Obstacle = 1'b0;
    tick(6);
    check("rev_tmr_cleared", State, S_MV_UP);
    UP_Max = 1'b1;
    tick();
    check("up_limit_state", State, S_IDLE);
    check("up_limit_up_m", UP_M, 0);

    // 4: pause and resume in opposite direction
    UP_Max = 1'b0;
    press();
    check("noLimit_press_state", State, S_MV_UP);
    press();
    check("halt_state", State, S_HALT);
    check("halt_up_m", UP_M, 0);
    check("halt_dn_m", DN_M, 0);
    press();
    check("resume_dn_m", DN_M, 1);
    check("resume_dn_state", State, S_MV_DN);
    press();
    check("halt2_state", State, S_HALT);
    Obstacle = 1'b1;
    tick();
    check("halt_obstacle_stay", State, S_HALT);
    Obstacle = 1'b0;
    press();
    check("resume_up_m", UP_M, 1);

    // 5: watchdog: exactly 8 motor-on cycles
    tick(7);
    check("wd_still_up", UP_M, 1);
    tick();
    check("wd_fault", Fault, 1);
    check("wd_up_m", UP_M, 0);
    check("wd_state", State, S_FAULT);
    press();
    DN_Max = 1'b1;
    tick();
    check("fault_latched", State, S_FAULT);
    DN_Max = 1'b0;
    do_reset();
    check("fault_rst_state", State, S_IDLE);
    check("fault_rst_flag", Fault, 0);

    // limit and press in the same cycle: limit wins, press dropped
    press();
    Activate = 1'b1;
    tick();
    Activate = 1'b0;
    tick();
    UP_Max = 1'b1;
    tick();
    check("limit_beats_act", State, S_IDLE);
    tick();
    check("act_dropped", State, S_IDLE);

    // 6: both limits while closing -> fault
    press();
    check("both_pre_state", State, S_MV_DN);
    DN_Max = 1'b1;
    tick();
    check("both_limits_fault", State, S_FAULT);
    check("both_limits_dn_m", DN_M, 0);
    do_reset();
    DN_Max = 1'b0;

    // reset mid-motion
    UP_Max = 1'b0;
    press();
    check("mid_pre_up_m", UP_M, 1);
    RST = 1'b1;
    tick();
    check("mid_rst_up_m", UP_M, 0);
    check("mid_rst_state", State, S_IDLE);

    // button held through reset yields one pulse after release
    Activate = 1'b1;
    tick();
    RST = 1'b0;
    tick(2);
    check("held_rst_wait", State, S_IDLE);
    tick();
    check("held_rst_move", State, S_MV_UP);
    Activate = 1'b0;
    do_reset();

    // auto-close
    UP_Max = 1'b1;
    do_reset();
`ifdef AGDC_AUTO_CLOSE_EN
    tick(15);
    check("ac_wait_state", State, S_IDLE);
    tick();
    check("ac_close_dn_m", DN_M, 1);
`else
    tick(20);
    check("no_ac_state", State, S_IDLE);
    check("no_ac_dn_m", DN_M, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
